// File: rtl/ln_stats_stream.sv
// Streaming LayerNorm statistics: mean and saturated variance of an N = LANES*BEATS
// element signed fixed-point vector, fed LANES elements per beat.
module ln_stats_stream #(
   parameter int LANES  = 16,
   parameter int BEATS  = 4,
   parameter int DATA_W = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*DATA_W-1:0]   in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         mean_out,
   output logic [DATA_W-1:0]         var_out,
   output logic                      busy
);

   localparam int FRAC  = DATA_W / 2;
   localparam int LOG_L = $clog2(LANES);
   localparam int LOG_N = LOG_L + $clog2(BEATS);
   localparam int LAT   = LOG_L + 4;
   localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int DR_W  = $clog2(LAT);
   localparam int SW    = DATA_W + LOG_N;
   localparam int QW    = 2 * DATA_W + LOG_N;

   typedef enum logic [1:0] {ST_ACCUM = 2'd0, ST_WAIT = 2'd1, ST_OUT = 2'd2} state_e;

   state_e            state_q, state_d;
   logic [BC_W-1:0]   beat_q, beat_d;
   logic [DR_W-1:0]   drain_q, drain_d;
   logic              accept_s, last_beat_s, clear_s;

   function automatic logic [2*DATA_W-1:0] sq_f(input logic signed [DATA_W-1:0] x);
      logic signed [2*DATA_W-1:0] xe;
      xe = (2*DATA_W)'(x);
      return $unsigned(xe * xe);
   endfunction

   assign accept_s    = in_valid && (state_q == ST_ACCUM);
   assign last_beat_s = accept_s && (beat_q == BC_W'(BEATS - 1));
   assign clear_s     = (state_q == ST_OUT) && out_ready;

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_ACCUM;
         beat_q  <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         drain_q <= drain_d;
      end
   end

   // next-state logic; the drain count is loaded so OUT is entered LAT edges after the last beat
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      drain_d = drain_q;
      case (state_q)
         ST_ACCUM: begin
            if (last_beat_s) begin
               beat_d  = '0;
               drain_d = DR_W'(LAT - 1);
               state_d = ST_WAIT;
            end else if (accept_s) begin
               beat_d = beat_q + 1'b1;
            end else begin
               beat_d = beat_q;
            end
         end
         ST_WAIT: begin
            if (drain_q == '0) begin
               state_d = ST_OUT;
            end else begin
               drain_d = drain_q - 1'b1;
            end
         end
         ST_OUT: begin
            if (out_ready) begin
               state_d = ST_ACCUM;
            end else begin
               state_d = ST_OUT;
            end
         end
         default: state_d = ST_ACCUM;
      endcase
   end

   // handshake and status outputs decoded from the registered state
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_ACCUM: in_ready  = 1'b1;
         ST_WAIT:  in_ready  = 1'b0;
         ST_OUT:   out_valid = 1'b1;
         default:  in_ready  = 1'b0;
      endcase
      busy = (state_q != ST_ACCUM) || (beat_q != '0);
   end

   // Level 0 holds elements and squares; each further level halves the lane count, growing 1 bit.
   for (genvar lv = 0; lv <= LOG_L; lv++) begin : g_lvl
      localparam int CNT = LANES >> lv;
      localparam int W   = DATA_W + lv;
      localparam int QL  = 2 * DATA_W + lv;
      logic signed [W-1:0]  s_q [CNT];
      logic        [QL-1:0] q_q [CNT];
      logic                 v_q, l_q;

      if (lv == 0) begin : g_in
         // element and square capture on accepted beats
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               v_q <= 1'b0;
               l_q <= 1'b0;
               for (int i = 0; i < CNT; i++) begin
                  s_q[i] <= '0;
                  q_q[i] <= '0;
               end
            end else begin
               v_q <= accept_s;
               l_q <= last_beat_s;
               if (accept_s) begin
                  for (int i = 0; i < CNT; i++) begin
                     s_q[i] <= $signed(in_data[i*DATA_W +: DATA_W]);
                     q_q[i] <= sq_f($signed(in_data[i*DATA_W +: DATA_W]));
                  end
               end
            end
         end
      end else begin : g_add
         // pairwise adder-tree level
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               v_q <= 1'b0;
               l_q <= 1'b0;
               for (int i = 0; i < CNT; i++) begin
                  s_q[i] <= '0;
                  q_q[i] <= '0;
               end
            end else begin
               v_q <= g_lvl[lv-1].v_q;
               l_q <= g_lvl[lv-1].l_q;
               if (g_lvl[lv-1].v_q) begin
                  for (int i = 0; i < CNT; i++) begin
                     s_q[i] <= W'(g_lvl[lv-1].s_q[2*i]) + W'(g_lvl[lv-1].s_q[2*i+1]);
                     q_q[i] <= QL'(g_lvl[lv-1].q_q[2*i]) + QL'(g_lvl[lv-1].q_q[2*i+1]);
                  end
               end
            end
         end
      end
   end

   logic signed [SW-1:0]     sum_acc_q;
   logic        [QW-1:0]     sq_acc_q;
   logic                     acc_last_q;
   logic signed [DATA_W-1:0] mean_f1_q;
   logic [2*DATA_W-1:0]      ex2_f1_q;
   logic                     f1_v_q;
   logic [DATA_W-1:0]        mean_q, var_q;
   logic [DATA_W-1:0]        var_d;
   logic [2*DATA_W-1:0]      msq_s, dpos_s, vsh_s;
   logic [2*DATA_W:0]        diff_s;

   // vector accumulators, cleared when the result is taken
   always_ff @(posedge clk) begin
      if (!rst_n || clear_s) begin
         sum_acc_q  <= '0;
         sq_acc_q   <= '0;
         acc_last_q <= 1'b0;
      end else begin
         acc_last_q <= g_lvl[LOG_L].v_q && g_lvl[LOG_L].l_q;
         if (g_lvl[LOG_L].v_q) begin
            sum_acc_q <= sum_acc_q + SW'(g_lvl[LOG_L].s_q[0]);
            sq_acc_q  <= sq_acc_q + QW'(g_lvl[LOG_L].q_q[0]);
         end
      end
   end

   // F1: floor mean and E[x^2]
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         f1_v_q    <= 1'b0;
         mean_f1_q <= '0;
         ex2_f1_q  <= '0;
      end else begin
         f1_v_q <= acc_last_q;
         if (acc_last_q) begin
            mean_f1_q <= DATA_W'(sum_acc_q >>> LOG_N);
            ex2_f1_q  <= (2*DATA_W)'(sq_acc_q >> LOG_N);
         end
      end
   end

   // F2 combinational: E[x^2] - mean^2, clamped at zero, rescaled and saturated
   always_comb begin
      msq_s  = sq_f(mean_f1_q);
      diff_s = {1'b0, ex2_f1_q} - {1'b0, msq_s};
      if (diff_s[2*DATA_W]) begin
         dpos_s = '0;
      end else begin
         dpos_s = diff_s[2*DATA_W-1:0];
      end
      vsh_s = dpos_s >> FRAC;
      if (|vsh_s[2*DATA_W-1:DATA_W]) begin
         var_d = '1;
      end else begin
         var_d = vsh_s[DATA_W-1:0];
      end
   end

   // F2 result registers drive the outputs and hold until the next vector completes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mean_q <= '0;
         var_q  <= '0;
      end else if (f1_v_q) begin
         mean_q <= mean_f1_q;
         var_q  <= var_d;
      end else begin
         mean_q <= mean_q;
         var_q  <= var_q;
      end
   end

   assign mean_out = mean_q;
   assign var_out  = var_q;

endmodule

// File: tb/tb_ln_stats_stream.sv
// Directed plus randomized bench for ln_stats_stream against an arithmetic reference model.
module tb_ln_stats_stream;

   localparam int LANES = 16;
   localparam int BEATS = 4;
   localparam int DW    = 16;
   localparam int N     = LANES * BEATS;
   localparam int LAT   = 8;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  in_valid;
   logic                  in_ready;
   logic [LANES*DW-1:0]   in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DW-1:0]         mean_out;
   logic [DW-1:0]         var_out;
   logic                  busy;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   logic [DW-1:0] vec [N];
   logic [DW-1:0] em, ev;

   always #5 clk = ~clk;

   ln_stats_stream #(.LANES(LANES), .BEATS(BEATS), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .mean_out(mean_out), .var_out(var_out), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: floor mean and clamped, saturated variance from plain integer arithmetic.
   task automatic model(output logic [DW-1:0] m, output logic [DW-1:0] v);
      longint s, sq, q, ex2, d, e;
      s  = 0;
      sq = 0;
      for (int i = 0; i < N; i++) begin
         e  = longint'($signed(vec[i]));
         s  += e;
         sq += e * e;
      end
      q = s / N;
      if ((s % N) != 0 && s < 0) q = q - 1;
      ex2 = sq / N;
      d = ex2 - q * q;
      if (d < 0) d = 0;
      d = d / 256;
      if (d > 65535) d = 65535;
      m = q[DW-1:0];
      v = d[DW-1:0];
   endtask

   task automatic send_beat(input int b);
      for (int l = 0; l < LANES; l++) in_data[l*DW +: DW] = vec[b*LANES + l];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_vector(input string tag, input int gap);
      for (int b = 0; b < BEATS; b++) begin
         send_beat(b);
         if (b < BEATS - 1) begin
            for (int g = 0; g < gap; g++) begin
               @(posedge clk);
               #1;
               check({tag, "_gap_ready"}, {31'd0, in_ready}, 32'd1);
               check({tag, "_gap_busy"}, {31'd0, busy}, 32'd1);
            end
         end
      end
   endtask

   task automatic wait_result(input string tag, input logic [DW-1:0] m, input logic [DW-1:0] v);
      int cyc;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 30) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check({tag, "_latency"}, cyc, LAT);
      check({tag, "_mean"}, {16'd0, mean_out}, {16'd0, m});
      check({tag, "_var"}, {16'd0, var_out}, {16'd0, v});
      check({tag, "_ready_low"}, {31'd0, in_ready}, 32'd0);
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic run_vec(input string tag, input int gap, input logic [DW-1:0] m, input logic [DW-1:0] v);
      send_vector(tag, gap);
      wait_result(tag, m, v);
      handshake(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_mean", {16'd0, mean_out}, 32'd0);
      check("rst_var", {16'd0, var_out}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);

      for (int i = 0; i < N; i++) vec[i] = 16'h0100;
      run_vec("ones", 0, 16'h0100, 16'h0000);

      for (int i = 0; i < N; i++) vec[i] = (i % 2 == 0) ? 16'h0200 : 16'hFE00;
      run_vec("alt2", 0, 16'h0000, 16'h0400);
      run_vec("alt2_gaps", 2, 16'h0000, 16'h0400);

      for (int i = 0; i < N; i++) vec[i] = 16'h0000;
      vec[0] = 16'hFFFF;
      run_vec("neg_lsb", 0, 16'hFFFF, 16'h0000);
      vec[0] = 16'h0001;
      run_vec("pos_lsb", 0, 16'h0000, 16'h0000);

      for (int i = 0; i < N; i++) vec[i] = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
      run_vec("extreme", 0, 16'hFFFF, 16'hFFFF);

      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < N; i++) begin
            if (r % 2 == 0) vec[i] = 16'($urandom_range(0, 2047)) - 16'd1024;
            else            vec[i] = 16'($urandom);
         end
         model(em, ev);
         run_vec("rand", r, em, ev);
      end

      // backpressure: result must hold and extra beats must be ignored
      for (int i = 0; i < N; i++) vec[i] = 16'($urandom_range(0, 4095)) - 16'd2048;
      model(em, ev);
      send_vector("bp", 0);
      wait_result("bp", em, ev);
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         in_data  = {LANES{16'h1234}};
         @(posedge clk);
         #1;
         check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         check("bp_hold_mean", {16'd0, mean_out}, {16'd0, em});
         check("bp_hold_var", {16'd0, var_out}, {16'd0, ev});
         check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      handshake("bp");
      for (int i = 0; i < N; i++) vec[i] = 16'($urandom_range(0, 511)) - 16'd256;
      model(em, ev);
      run_vec("after_bp", 1, em, ev);

      // reset mid-vector discards the partial beats
      for (int i = 0; i < N; i++) vec[i] = 16'h4000;
      send_beat(0);
      send_beat(1);
      check("mid_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
      check("mrst_busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < N; i++) vec[i] = 16'h0100;
      run_vec("post_rst", 0, 16'h0100, 16'h0000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ln_stats_stream.md
Name: ln_stats_stream

Overview:
- Streaming LayerNorm statistics unit: accepts a vector of N = LANES*BEATS signed Q8.8 elements, LANES elements per beat over BEATS beats.
- Returns the vector mean (Q8.8, signed) and the variance (Q8.8, unsigned, saturating).
- Generalises the fixed 16-lane mean-only adder tree: parametrised lanes, multi-beat vectors, variance, and valid/ready handshakes on both sides.
- Sits in the LN datapath ahead of the normalise/scale stage.

Parameters:
- LANES, 16, elements per beat; power of two, >= 2.
- BEATS, 4, beats per vector; power of two, >= 1.
- DATA_W, 16, element width (Q8.8 when 16); FRAC = DATA_W/2 fractional bits.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  LANES*DATA_W  element i at [i*DATA_W +: DATA_W], two's complement.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- mean_out  out  DATA_W  mean, signed Q8.8.
- var_out  out  DATA_W  variance, unsigned Q8.8, saturated.
- busy  out  1  high when the FSM is not in ACCUM, or beat_cnt != 0.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=ACCUM, beat_cnt=0, accumulators=0, pipeline valid bits=0.
  - in_ready=1, out_valid=0, mean_out=0, var_out=0, busy=0.
  - Reset mid-vector or mid-output discards all partial work.
- FSM states: ACCUM, WAIT, OUT.
  - ACCUM:
    - in_ready=1; beat accepted when in_valid & in_ready; beat_cnt increments per accepted beat.
    - Idle cycles (in_valid=0) between beats are allowed; beat_cnt holds.
    - On the accepted beat with beat_cnt==BEATS-1: beat_cnt->0, state->WAIT.
  - WAIT:
    - in_ready=0; a down-counter runs the fixed pipeline drain.
    - state->OUT so that out_valid rises exactly LAT = log2(LANES)+4 cycles after the edge accepting the last beat (LANES=16 -> 8).
  - OUT:
    - out_valid=1; mean_out and var_out stable; in_ready=0.
    - On out_valid & out_ready: out_valid->0, state->ACCUM, accumulators cleared; in_ready=1 the following cycle.
- Pipeline (non-stalling; runs only on accepted beats):
  - Stage 1 registers each element and its square: signed product, 2*DATA_W bits, Q16.16.
  - log2(LANES) registered pairwise adder-tree stages for the sums and the sums of squares; each level grows 1 bit.
  - 1 accumulate stage: sum_acc width DATA_W+log2(N) signed; sq_acc width 2*DATA_W+log2(N) unsigned.
  - 2 finalise stages:
    - F1: mean = sum_acc >>> log2(N) (arithmetic, floor toward -inf), truncated to DATA_W. ex2 = sq_acc >> log2(N).
    - F2: msq = mean*mean (Q16.16); d = ex2 - msq; if d < 0 then d = 0. var = d >> FRAC; saturate to 2^DATA_W-1 if it overflows DATA_W.
- No overflow is possible in the tree or accumulators; no rounding anywhere (floor only).
- in_valid while in_ready=0: ignored, no state change.
- out_ready before out_valid: no effect.

Test Plan:
- Defaults (LANES=16, BEATS=4, N=64). All 64 elements 0x0100 -> mean_out=0x0100, var_out=0x0000; out_valid rises 8 cycles after the last-beat edge.
- Elements alternating 0x0200/0xFE00 (+2/-2) -> mean_out=0x0000, var_out=0x0400 (4.0).
- One element 0xFFFF, rest 0 -> sum=-1, mean_out=0xFFFF (floor). ex2=0, msq=1, so d is clamped -> var_out=0x0000. Repeat with 0x0001 -> mean_out=0x0000, var_out=0x0000.
- Elements alternating 0x7FFF/0x8000 -> mean_out=0xFFFF; variance ~2^22 LSB -> var_out=0xFFFF (saturated).
- Backpressure and bubbles:
  - Beats sent with 2-cycle in_valid gaps; result unchanged vs. back-to-back.
  - Hold out_ready=0 for 5 cycles -> out_valid, mean_out and var_out stable, in_ready=0, extra in_valid ignored.
  - After the handshake, the next vector is accepted and its result is correct.
- Pull rst_n low for 1 cycle after 2 of 4 beats -> out_valid stays 0, in_ready=1 next cycle. A fresh full vector of 0x0100 yields mean_out=0x0100 with no contamination from the discarded beats.
